calc_ctrl: RTL

Sequencing controller for the 4-digit BCD add/subtract ALU. Consumes one-cycle key events from the keypad decoder, builds operand 1 and operand 2 digit by digit, and drives the ALU operand and operation inputs. It samples the combinational ALU result on '=' or on a chained operator, and selects the 4-digit BCD value shown on the 7-segment display driver.

---
 rtl/calc_pkg.sv | 26 ++
 rtl/bcd_entry_reg.sv | 47 ++++
 rtl/calc_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencing controller.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_NUM1   = 2'd0,
    ST_OP     = 2'd1,
    ST_NUM2   = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  localparam logic [3:0] KEY_ADD_DEF = 4'hA;
  localparam logic [3:0] KEY_SUB_DEF = 4'hB;
  localparam logic [3:0] KEY_EQ_DEF  = 4'hC;
  localparam logic [3:0] KEY_CLR_DEF = 4'hD;

  localparam int MAX_DIGITS_DEF = 4;
  localparam int CNT_W          = 3;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// 16-bit BCD operand register: digits shift in from the right, counted up to MAX_DIGITS.
module bcd_entry_reg
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        load_digit_i,
  input  logic [3:0]  digit_i,
  input  logic        load_value_i,
  input  logic [15:0] value_i,
  output logic [15:0] value_o
);

  logic [15:0]      value_q, value_d, base_value;
  logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt;

  // clear together with load_digit starts a fresh operand holding one digit
  always_comb begin
    base_value = clear_i ? 16'h0000 : value_q;
    base_cnt   = clear_i ? '0 : cnt_q;
    value_d    = base_value;
    cnt_d      = base_cnt;
    if (load_value_i) begin
      value_d = value_i;
      cnt_d   = '0;
    end else if (load_digit_i && (base_cnt < CNT_W'(MAX_DIGITS))) begin
      value_d = {base_value[11:0], digit_i};
      cnt_d   = base_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= 16'h0000;
      cnt_q   <= '0;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/calc_ctrl.sv
// Key-driven sequencer for the BCD add/subtract ALU and display mux.
// Optional: CALC_CHAIN_RESULT_EN lets +/- after '=' reuse the result as operand 1.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int         MAX_DIGITS = MAX_DIGITS_DEF,
  parameter logic [3:0] KEY_ADD    = KEY_ADD_DEF,
  parameter logic [3:0] KEY_SUB    = KEY_SUB_DEF,
  parameter logic [3:0] KEY_EQ     = KEY_EQ_DEF,
  parameter logic [3:0] KEY_CLR    = KEY_CLR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] alu_result,
  output logic [15:0] num1_bcd,
  output logic [15:0] num2_bcd,
  output logic [1:0]  operacion,
  output logic [15:0] disp_bcd,
  output logic [1:0]  estado
);

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] res_q, res_value;
  logic        res_load, res_clear, op_load;
  logic        n1_clear, n1_digit, n1_load;
  logic        n2_clear, n2_digit;
  logic [15:0] n1_value;
  logic        key_dig, key_op, key_eq, key_clr;

  assign key_dig = key_valid && is_digit(key_code);
  assign key_op  = key_valid && ((key_code == KEY_ADD) || (key_code == KEY_SUB));
  assign key_eq  = key_valid && (key_code == KEY_EQ);
  assign key_clr = key_valid && (key_code == KEY_CLR);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_NUM1;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (key_clr) begin
      state_d = ST_NUM1;
    end else begin
      case (state_q)
        ST_NUM1:   if (key_op) state_d = ST_OP;
        ST_OP: begin
          if (key_dig)     state_d = ST_NUM2;
          else if (key_eq) state_d = ST_RESULT;
        end
        ST_NUM2: begin
          if (key_eq)      state_d = ST_RESULT;
          else if (key_op) state_d = ST_OP;
        end
        ST_RESULT: begin
          if (key_dig) state_d = ST_NUM1;
`ifdef CALC_CHAIN_RESULT_EN
          else if (key_op) state_d = ST_OP;
`endif
        end
        default:   state_d = ST_NUM1;
      endcase
    end
  end

  always_comb begin
    n1_clear  = 1'b0;
    n1_digit  = 1'b0;
    n1_load   = 1'b0;
    n1_value  = alu_result;
    n2_clear  = 1'b0;
    n2_digit  = 1'b0;
    op_load   = 1'b0;
    op_d      = (key_code == KEY_SUB) ? OP_SUB : OP_ADD;
    res_load  = 1'b0;
    res_clear = 1'b0;
    res_value = alu_result;
    if (key_clr) begin
      n1_clear  = 1'b1;
      n2_clear  = 1'b1;
      op_load   = 1'b1;
      op_d      = OP_ADD;
      res_clear = 1'b1;
    end else begin
      case (state_q)
        ST_NUM1: begin
          n1_digit = key_dig;
          op_load  = key_op;
        end
        ST_OP: begin
          n2_clear  = key_dig;
          n2_digit  = key_dig;
          op_load   = key_op;
          res_load  = key_eq;
          res_value = num1_bcd;
        end
        ST_NUM2: begin
          n2_digit = key_dig;
          res_load = key_eq;
          n1_load  = key_op;
          n2_clear = key_op;
          op_load  = key_op;
        end
        ST_RESULT: begin
          n1_clear = key_dig;
          n1_digit = key_dig;
          n2_clear = key_dig;
`ifdef CALC_CHAIN_RESULT_EN
          if (key_op) begin
            n1_load  = 1'b1;
            n1_value = res_q;
            n2_clear = 1'b1;
            op_load  = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= 16'h0000;
      op_q  <= OP_ADD;
    end else begin
      if (res_clear)     res_q <= 16'h0000;
      else if (res_load) res_q <= res_value;
      if (op_load) op_q <= op_d;
    end
  end

  bcd_entry_reg #(.MAX_DIGITS(MAX_DIGITS)) u_num1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (n1_clear),
    .load_digit_i (n1_digit),
    .digit_i      (key_code),
    .load_value_i (n1_load),
    .value_i      (n1_value),
    .value_o      (num1_bcd)
  );

  bcd_entry_reg #(.MAX_DIGITS(MAX_DIGITS)) u_num2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (n2_clear),
    .load_digit_i (n2_digit),
    .digit_i      (key_code),
    .load_value_i (1'b0),
    .value_i      (16'h0000),
    .value_o      (num2_bcd)
  );

  always_comb begin
    case (state_q)
      ST_NUM2:   disp_bcd = num2_bcd;
      ST_RESULT: disp_bcd = res_q;
      default:   disp_bcd = num1_bcd;
    endcase
  end

  assign operacion = op_q;
  assign estado    = state_q;

endmodule
